// File: rtl/blur_window_sequencer.sv
// Sequences one edge-clamped 3x3 Gaussian blur pass: kernel reads, window assembly and result write-back.
// Optional feature macro: BLUR_TIMEOUT_EN aborts a pass if the blur unit is silent for BLUR_TIMEOUT cycles.
module blur_window_sequencer #(
  parameter int BIT_DEPTH    = 8,
  parameter int MAX_DIM      = 128,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int BLUR_TIMEOUT = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [7:0]             width_in,
  input  logic [7:0]             height_in,
  input  logic [ADDR_WIDTH-1:0]  src_base_in,
  input  logic [ADDR_WIDTH-1:0]  dst_base_in,
  output logic [ADDR_WIDTH-1:0]  rd_addr_out,
  output logic                   rd_en_out,
  input  logic [BIT_DEPTH-1:0]   rd_data_in,
  output logic [3*BIT_DEPTH-1:0] row0_out,
  output logic [3*BIT_DEPTH-1:0] row1_out,
  output logic [3*BIT_DEPTH-1:0] row2_out,
  output logic                   window_valid_out,
  input  logic                   blur_valid_in,
  input  logic [BIT_DEPTH-1:0]   blur_data_in,
  output logic [ADDR_WIDTH-1:0]  wr_addr_out,
  output logic [BIT_DEPTH-1:0]   wr_data_out,
  output logic                   wr_en_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   error_out,
  output logic [2:0]             state_dbg_out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_BLUR = 3'd2,
    S_WRITE     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam int         FETCH_LAST = 9 + READ_LATENCY;
  localparam int         FCW        = $clog2(FETCH_LAST + 1);
  localparam logic [8:0] MAX_DIM_L  = 9'(MAX_DIM);

  state_t                 state_q, state_d;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic [1:0]             kx_q, kx_d, ky_q, ky_d;
  logic [7:0]             x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [ADDR_WIDTH-1:0]  src_q, src_d, dst_q, dst_d;
  logic [BIT_DEPTH-1:0]   res_q, res_d;
  logic                   err_q, err_d;
  logic [BIT_DEPTH-1:0]   win_q [9];
`ifdef BLUR_TIMEOUT_EN
  localparam int TCW = $clog2(BLUR_TIMEOUT + 1);
  logic [TCW-1:0]         tcnt_q, tcnt_d;
`endif

  logic                   dims_ok;
  logic                   issue;
  logic                   cap_en;
  logic [3:0]             cap_idx;
  logic [7:0]             nx, ny;
  logic [15:0]            rd_prod, wr_prod;
  logic [ADDR_WIDTH-1:0]  rd_addr, wr_addr;

  assign dims_ok = (width_in != 8'd0) && ({1'b0, width_in} <= MAX_DIM_L) &&
                   (height_in != 8'd0) && ({1'b0, height_in} <= MAX_DIM_L);
  assign issue   = (state_q == S_FETCH) && (fcnt_q < FCW'(9));
  // Read k returns READ_LATENCY cycles after its issue, landing in window slot k.
  assign cap_en  = (state_q == S_FETCH) && (fcnt_q >= FCW'(READ_LATENCY)) &&
                   (fcnt_q < FCW'(READ_LATENCY + 9));
  assign cap_idx = 4'(fcnt_q - FCW'(READ_LATENCY));

  always_comb begin
    nx = x_q;
    ny = y_q;
    if (kx_q == 2'd0)      nx = (x_q == 8'd0) ? 8'd0 : x_q - 8'd1;
    else if (kx_q == 2'd2) nx = (x_q == w_q - 8'd1) ? x_q : x_q + 8'd1;
    if (ky_q == 2'd0)      ny = (y_q == 8'd0) ? 8'd0 : y_q - 8'd1;
    else if (ky_q != 2'd1) ny = (y_q == h_q - 8'd1) ? y_q : y_q + 8'd1;
    rd_prod = {8'd0, ny} * {8'd0, w_q};
    wr_prod = {8'd0, y_q} * {8'd0, w_q};
    rd_addr = src_q + ADDR_WIDTH'(rd_prod) + ADDR_WIDTH'(nx);
    wr_addr = dst_q + ADDR_WIDTH'(wr_prod) + ADDR_WIDTH'(x_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
`ifdef BLUR_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      res_q   <= res_d;
      err_q   <= err_d;
      if (cap_en) win_q[cap_idx] <= rd_data_in;
`ifdef BLUR_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // window_valid_out and blur_valid_in are single-cycle strobes with no backpressure:
  // a window is offered once, and a blur result is accepted only while waiting for one.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    src_d   = src_q;
    dst_d   = dst_q;
    res_d   = res_q;
    err_d   = blur_valid_in && (state_q != S_WAIT_BLUR);
`ifdef BLUR_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (dims_ok) begin
            w_d     = width_in;
            h_d     = height_in;
            src_d   = src_base_in;
            dst_d   = dst_base_in;
            x_d     = 8'd0;
            y_d     = 8'd0;
            fcnt_d  = '0;
            kx_d    = 2'd0;
            ky_d    = 2'd0;
            state_d = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (issue) begin
          if (kx_q == 2'd2) begin
            kx_d = 2'd0;
            ky_d = ky_q + 2'd1;
          end else begin
            kx_d = kx_q + 2'd1;
          end
        end
        if (fcnt_q == FCW'(FETCH_LAST)) begin
          state_d = S_WAIT_BLUR;
`ifdef BLUR_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      S_WAIT_BLUR: begin
        if (blur_valid_in) begin
          res_d   = blur_data_in;
          state_d = S_WRITE;
        end
`ifdef BLUR_TIMEOUT_EN
        else if (tcnt_q == TCW'(BLUR_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
`endif
      end
      S_WRITE: begin
        fcnt_d  = '0;
        kx_d    = 2'd0;
        ky_d    = 2'd0;
        state_d = S_FETCH;
        if (x_q == w_q - 8'd1) begin
          x_d = 8'd0;
          if (y_q == h_q - 8'd1) state_d = S_DONE;
          else                   y_d = y_q + 8'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en_out        = issue;
    rd_addr_out      = issue ? rd_addr : '0;
    window_valid_out = (state_q == S_FETCH) && (fcnt_q == FCW'(FETCH_LAST));
    wr_en_out        = (state_q == S_WRITE);
    wr_addr_out      = (state_q == S_WRITE) ? wr_addr : '0;
    wr_data_out      = (state_q == S_WRITE) ? res_q : '0;
    busy_out         = (state_q != S_IDLE);
    done_out         = (state_q == S_DONE);
    error_out        = err_q;
    state_dbg_out    = state_q;
    row0_out         = {win_q[2], win_q[1], win_q[0]};
    row1_out         = {win_q[5], win_q[4], win_q[3]};
    row2_out         = {win_q[8], win_q[7], win_q[6]};
  end

endmodule

// File: tb/tb_blur_window_sequencer.sv
// Directed bench for blur_window_sequencer: BRAM model returning mem[a]=a, a centre-pixel blur model,
// and hand-computed read addresses, windows, writes and cycle counts.
module tb_blur_window_sequencer;
  localparam int BD = 8;
  localparam int AW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic [7:0]    width_in = '0, height_in = '0;
  logic [AW-1:0] src_base_in = '0, dst_base_in = '0;
  logic [AW-1:0] rd_addr_out;
  logic          rd_en_out;
  logic [BD-1:0] rd_data_in;
  logic [3*BD-1:0] row0_out, row1_out, row2_out;
  logic          window_valid_out;
  logic          blur_valid_in;
  logic [BD-1:0] blur_data_in;
  logic [AW-1:0] wr_addr_out;
  logic [BD-1:0] wr_data_out;
  logic          wr_en_out, busy_out, done_out, error_out;
  logic [2:0]    state_dbg_out;

  blur_window_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .width_in(width_in), .height_in(height_in),
    .src_base_in(src_base_in), .dst_base_in(dst_base_in),
    .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
    .row0_out(row0_out), .row1_out(row1_out), .row2_out(row2_out),
    .window_valid_out(window_valid_out),
    .blur_valid_in(blur_valid_in), .blur_data_in(blur_data_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
    .state_dbg_out(state_dbg_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // BRAM model, two-cycle latency, mem[a] = a[7:0]
  logic [7:0] rd_pipe;
  always @(posedge clk_in) begin
    rd_pipe    <= rd_addr_out[7:0];
    rd_data_in <= rd_pipe;
  end

  // blur model: returns the centre pixel three cycles after window_valid_out
  logic          mdl_en = 1'b1;
  logic          mdl_valid = 1'b0;
  logic          inj_valid = 1'b0;
  logic [BD-1:0] mdl_data = '0;
  int            mdl_cnt = 0;
  assign blur_valid_in = mdl_valid | inj_valid;
  assign blur_data_in  = mdl_data;
  always @(negedge clk_in) begin
    mdl_valid = 1'b0;
    if (mdl_cnt != 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) mdl_valid = 1'b1;
    end
    if (window_valid_out && mdl_en) begin
      mdl_cnt  = 3;
      mdl_data = row1_out[2*BD-1:BD];
    end
  end

  // monitor: logs reads, writes, error pulses and windows
  logic [AW-1:0]      rd_log[$];
  logic [AW+BD-1:0]   act_q[$];
  logic [AW+BD-1:0]   exp_q[$];
  int                 err_total = 0;
  int                 win_total = 0;
  logic [3*BD-1:0]    first_r0, first_r1, first_r2, last_r0, last_r1, last_r2;
  always @(negedge clk_in) begin
    if (rd_en_out) rd_log.push_back(rd_addr_out);
    if (wr_en_out) act_q.push_back({wr_addr_out, wr_data_out});
    if (error_out) err_total++;
    if (window_valid_out) begin
      if (win_total == 0) begin
        first_r0 = row0_out; first_r1 = row1_out; first_r2 = row2_out;
      end
      last_r0 = row0_out; last_r1 = row1_out; last_r2 = row2_out;
      win_total++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input string tag, input logic [7:0] w, input logic [7:0] h,
                          input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int inj_at, input int exp_cyc, input int exp_err);
    int cyc, reads, done_seen, base_wr, base_err, n_act, n_exp;
    logic [AW-1:0] pa;
    logic [AW-1:0] pd;
    logic [AW+BD-1:0] e;
    base_wr  = act_q.size();
    base_err = err_total;
    n_exp    = int'(w) * int'(h);
    for (int i = 0; i < n_exp; i++) begin
      pa = dst + AW'(i);
      pd = src + AW'(i);
      exp_q.push_back({pa, pd[BD-1:0]});
    end
    width_in = w; height_in = h; src_base_in = src; dst_base_in = dst;
    start_in = 1'b1;
    cyc = 0; reads = 0; done_seen = 0;
    while (cyc < 2000 && done_seen == 0) begin
      tick();
      cyc++;
      start_in  = 1'b0;
      inj_valid = 1'b0;
      if (rd_en_out) begin
        reads++;
        if (reads == inj_at) inj_valid = 1'b1;
      end
      if (done_out) done_seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    tick();
    chk({tag, "_done_one_cycle"}, 32'(done_out), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy_out), 32'd0);
    n_act = act_q.size() - base_wr;
    chk({tag, "_write_count"}, 32'(n_act), 32'(n_exp));
    for (int i = 0; i < n_act && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_write%0d", tag, i), 32'(act_q[base_wr+i]), 32'(e));
    end
    exp_q.delete();
    chk({tag, "_error_pulses"}, 32'(err_total - base_err), 32'(exp_err));
  endtask

  task automatic bad_start(input string tag, input logic [7:0] w, input logic [7:0] h);
    int errs, busy_any, rd_any;
    width_in = w; height_in = h; src_base_in = '0; dst_base_in = 16'd100;
    start_in = 1'b1;
    errs = 0; busy_any = 0; rd_any = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      start_in = 1'b0;
      if (error_out) errs++;
      if (busy_out)  busy_any = 1;
      if (rd_en_out) rd_any = 1;
    end
    chk({tag, "_error_pulses"}, 32'(errs), 32'd1);
    chk({tag, "_busy"}, 32'(busy_any), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_any), 32'd0);
  endtask

  initial begin
    int base_rd, reads, cyc;
    // reset state
    rst_in = 1'b1;
    repeat (3) tick();
    rst_in = 1'b0;
    tick();
    chk("rst_state", 32'(state_dbg_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_rd_en", 32'(rd_en_out), 32'd0);
    chk("rst_wr_en", 32'(wr_en_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    chk("rst_window", 32'(window_valid_out), 32'd0);
    chk("rst_row1", 32'(row1_out), 32'd0);

    // illegal dimensions
    bad_start("w0", 8'd0, 8'd4);
    bad_start("w129", 8'd129, 8'd4);

    // 4x4 pass: 16 pixels x 16 cycles, then DONE
    base_rd = rd_log.size();
    run_pass("p1", 8'd4, 8'd4, 16'd0, 16'd100, 0, 257, 0);
    chk("p1_read_count", 32'(rd_log.size() - base_rd), 32'd144);
    begin
      logic [AW-1:0] first_rd [9];
      logic [AW-1:0] last_rd [9];
      first_rd = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd4, 16'd4, 16'd5};
      last_rd  = '{16'd10, 16'd11, 16'd11, 16'd14, 16'd15, 16'd15, 16'd14, 16'd15, 16'd15};
      for (int k = 0; k < 9; k++) begin
        chk($sformatf("p1_rd00_%0d", k), 32'(rd_log[base_rd+k]), 32'(first_rd[k]));
        chk($sformatf("p1_rd33_%0d", k), 32'(rd_log[base_rd+135+k]), 32'(last_rd[k]));
      end
    end
    chk("p1_win00_row0", 32'(first_r0), 32'h010000);
    chk("p1_win00_row1", 32'(first_r1), 32'h010000);
    chk("p1_win00_row2", 32'(first_r2), 32'h050404);
    chk("p1_win33_row0", 32'(last_r0), 32'h0B0B0A);
    chk("p1_win33_row1", 32'(last_r1), 32'h0F0F0E);
    chk("p1_win33_row2", 32'(last_r2), 32'h0F0F0E);
    chk("p1_windows", 32'(win_total), 32'd16);

    // stray blur strobe during the third FETCH read
    run_pass("p2", 8'd4, 8'd4, 16'd0, 16'd100, 3, 257, 1);

    // reset on the fifth FETCH read
    width_in = 8'd4; height_in = 8'd4; src_base_in = '0; dst_base_in = 16'd100;
    start_in = 1'b1;
    reads = 0; cyc = 0;
    while (reads < 5 && cyc < 200) begin
      tick();
      start_in = 1'b0;
      cyc++;
      if (rd_en_out) reads++;
    end
    chk("p3_reads_before_rst", 32'(reads), 32'd5);
    cyc = act_q.size();
    rst_in = 1'b1;
    tick();
    chk("p3_state", 32'(state_dbg_out), 32'd0);
    chk("p3_busy", 32'(busy_out), 32'd0);
    chk("p3_rd_en", 32'(rd_en_out), 32'd0);
    chk("p3_rd_addr", 32'(rd_addr_out), 32'd0);
    chk("p3_wr_en", 32'(wr_en_out), 32'd0);
    chk("p3_window", 32'(window_valid_out), 32'd0);
    chk("p3_error", 32'(error_out), 32'd0);
    chk("p3_rows", 32'(row0_out | row1_out | row2_out), 32'd0);
    rst_in = 1'b0;
    repeat (20) tick();
    chk("p3_no_write", 32'(act_q.size() - cyc), 32'd0);
    chk("p3_idle_busy", 32'(busy_out), 32'd0);

    // full pass after the abort
    run_pass("p4", 8'd4, 8'd4, 16'd0, 16'd100, 0, 257, 0);

    // 1x1 image at a non-zero base: all nine reads hit the base
    base_rd = rd_log.size();
    run_pass("p5", 8'd1, 8'd1, 16'd40, 16'd200, 0, 17, 0);
    chk("p5_read_count", 32'(rd_log.size() - base_rd), 32'd9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("p5_rd%0d", k), 32'(rd_log[base_rd+k]), 32'd40);

`ifdef BLUR_TIMEOUT_EN
    // silent blur unit: error 64 cycles after entering WAIT_BLUR
    begin
      int n, seen_done, base_wr;
      mdl_en = 1'b0;
      base_wr = act_q.size();
      width_in = 8'd1; height_in = 8'd1; src_base_in = 16'd0; dst_base_in = 16'd100;
      start_in = 1'b1;
      n = 0;
      while (!window_valid_out && n < 100) begin
        tick();
        start_in = 1'b0;
        n++;
      end
      chk("to_window_seen", 32'(window_valid_out), 32'd1);
      n = 0; seen_done = 0;
      while (!error_out && n < 200) begin
        tick();
        n++;
        if (done_out) seen_done = 1;
      end
      chk("to_error_delay", 32'(n), 32'd65);
      chk("to_busy", 32'(busy_out), 32'd0);
      chk("to_done", 32'(seen_done), 32'd0);
      tick();
      chk("to_no_write", 32'(act_q.size() - base_wr), 32'd0);
      mdl_en = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blur_window_sequencer.md
Name: blur_window_sequencer

Overview:
Controller that sequences one Gaussian blur pass over one image stored in a pyramid BRAM.
- Walks every center pixel in raster order.
- Issues the 9 edge-saturated 3x3 kernel reads to the BRAM read port and assembles the three row words for the gaussian blur unit.
- Waits for the blur result and writes it back to a destination region.
- The pyramid top level invokes it once per (octave, blur level), using different base addresses and dimensions.

Parameters:
BIT_DEPTH, 8, pixel width in bits
MAX_DIM, 128, largest legal image width/height
ADDR_WIDTH, 16, BRAM address width
READ_LATENCY, 2, cycles from rd_en_out to valid rd_data_in
BLUR_TIMEOUT, 64, max cycles in WAIT_BLUR (only with BLUR_TIMEOUT_EN)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
start_in  in  1  begin pass; sampled only in IDLE
width_in  in  8  image width, latched at start
height_in  in  8  image height, latched at start
src_base_in  in  ADDR_WIDTH  source image base address, latched at start
dst_base_in  in  ADDR_WIDTH  destination image base address, latched at start
rd_addr_out  out  ADDR_WIDTH  BRAM read address
rd_en_out  out  1  BRAM read enable
rd_data_in  in  BIT_DEPTH  BRAM read data
row0_out/row1_out/row2_out  out  3*BIT_DEPTH  kernel rows (top/mid/bottom)
window_valid_out  out  1  one-cycle strobe: rows valid for blur unit
blur_valid_in  in  1  blur unit result strobe
blur_data_in  in  BIT_DEPTH  blur unit result
wr_addr_out  out  ADDR_WIDTH  destination write address
wr_data_out  out  BIT_DEPTH  destination write data
wr_en_out  out  1  one-cycle write strobe
busy_out  out  1  high in any state except IDLE
done_out  out  1  one-cycle strobe after last write
error_out  out  1  one-cycle error strobe

Behaviour:
- Reset: state IDLE; all outputs 0; x=y=0. Reset applies in any state and aborts a pass immediately; no write is issued.
- States: IDLE -> FETCH -> WAIT_BLUR -> WRITE -> (FETCH | DONE) -> IDLE.
- IDLE, start_in=1, with width and height both in 1..MAX_DIM: latch inputs, go to FETCH.
- IDLE, start_in=1, with either dimension 0 or >MAX_DIM: error_out pulses, stay in IDLE.
- start_in outside IDLE is ignored.
- FETCH, issue: 9 consecutive cycles of rd_en_out=1, kernel order ky=0..2 outer, kx=0..2 inner.
  - nx = clamp(x+kx-1, 0, W-1); ny = clamp(y+ky-1, 0, H-1).
  - rd_addr_out = src_base + ny*W + nx, computed modulo 2^ADDR_WIDTH.
- FETCH, capture: read k's data is captured READ_LATENCY cycles after its issue.
  - Slot layout: row ky bits [BIT_DEPTH*(kx+1)-1 : BIT_DEPTH*kx], so left pixel in LSBs.
  - rd_en_out is 0 while draining.
  - window_valid_out=1 for exactly one cycle, READ_LATENCY+1 cycles after the 9th read issue; then go to WAIT_BLUR.
  - row outputs hold their values until the next window is captured.
- WAIT_BLUR: on blur_valid_in, register blur_data_in and go to WRITE.
- WRITE: one cycle with wr_en_out=1, wr_addr_out = dst_base + y*W + x, wr_data_out = captured result. Then advance:
  - x+1 while x < W-1.
  - Otherwise x=0 and y+1.
  - If x=W-1 and y=H-1, go to DONE instead of FETCH.
- DONE: done_out=1 for one cycle, busy_out=0 from the next cycle, state IDLE.
- blur_valid_in outside WAIT_BLUR: error_out pulses for one cycle; the strobe is otherwise ignored and the state is unchanged.
- 1x1 image: all 9 reads address src_base.
- Per-pixel cycle count, absent stall: 9 + READ_LATENCY + 1 (FETCH) + blur wait + 1 (WRITE).

Optional Feature:
BLUR_TIMEOUT_EN:
- When defined: a counter runs in WAIT_BLUR. If BLUR_TIMEOUT cycles elapse without blur_valid_in, error_out pulses, the pass aborts to IDLE, done_out is not asserted, and no write occurs.
- When undefined: WAIT_BLUR waits indefinitely.

Test Plan:
- 4x4 image, src_base=0, mem[a]=a, dst_base=100, blur model returns the center pixel 3 cycles after window_valid_out -> 16 writes, mem[100+i]=i, done_out once, busy_out low afterwards.
- Same 4x4 image, center (0,0) -> reads 0,0,1,0,0,1,4,4,5; row0=row1={1,0,0}, row2={5,4,4} (left pixel in LSBs).
- Center (3,3) of the 4x4 image -> reads 10,11,11,14,15,15,14,15,15.
- start_in with width_in=0, and separately with width_in=129 -> error_out one-cycle pulse each time, busy_out stays 0, no rd_en_out.
- blur_valid_in pulsed during FETCH -> error_out pulse; the pass still completes 16 correct writes.
- rst_in asserted on the 5th FETCH read -> next cycle all outputs 0 and state IDLE; a new start_in then yields a full correct pass.
- With BLUR_TIMEOUT_EN and no blur response -> error_out exactly BLUR_TIMEOUT cycles after WAIT_BLUR entry, no wr_en_out, no done_out.
